// File: rtl/demux_1to4_64.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready holding register
// per channel; a stalled consumer only blocks words addressed to its own channel.
module demux_1to4_64 #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [1:0]       i_select,
   input  logic [WIDTH-1:0] i_data,
   output logic [3:0]       o_valid,
   input  logic [3:0]       i_ready,
   output logic [WIDTH-1:0] o_data_0,
   output logic [WIDTH-1:0] o_data_1,
   output logic [WIDTH-1:0] o_data_2,
   output logic [WIDTH-1:0] o_data_3,
   output logic             o_busy,
   output logic [2:0]       o_count
);

   logic [3:0]       r_full;
   logic [WIDTH-1:0] r_data [4];
   logic [2:0]       r_count;

   logic             w_accept;
   logic [3:0]       w_accept_oh;
   logic [3:0]       w_full_nxt;
   logic [2:0]       w_count_nxt;

   assign o_ready  = !r_full[i_select] | i_ready[i_select];
   assign w_accept = i_valid & o_ready;

   // A channel draining and accepting on the same edge stays full with the new word.
   always_comb begin
      w_accept_oh = '0;
      w_count_nxt = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         w_accept_oh[k] = w_accept && (i_select == 2'(k));
         w_full_nxt[k]  = (r_full[k] & ~i_ready[k]) | w_accept_oh[k];
         w_count_nxt    = w_count_nxt + {2'b00, w_full_nxt[k]};
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_full  <= '0;
         r_count <= '0;
         for (int unsigned k = 0; k < 4; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         r_full  <= w_full_nxt;
         r_count <= w_count_nxt;
         for (int unsigned k = 0; k < 4; k++) begin
            if (w_accept_oh[k]) begin
               r_data[k] <= i_data;
            end
         end
      end
   end

   assign o_valid  = r_full;
   assign o_data_0 = r_data[0];
   assign o_data_1 = r_data[1];
   assign o_data_2 = r_data[2];
   assign o_data_3 = r_data[3];
   assign o_count  = r_count;
   assign o_busy   = (r_count != 3'd0);

endmodule

// File: tb/tb_demux_1to4_64.sv
// Directed and randomized checks of demux_1to4_64 against a per-channel
// occupancy/data model kept in the bench.
module tb_demux_1to4_64;

   logic        clk;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [1:0]  i_select;
   logic [63:0] i_data;
   logic [3:0]  o_valid;
   logic [3:0]  i_ready;
   logic [63:0] o_data_0, o_data_1, o_data_2, o_data_3;
   logic        o_busy;
   logic [2:0]  o_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: which channels hold a word, and the word each holds.
   bit          m_full [4];
   logic [63:0] m_data [4];

   demux_1to4_64 #(.WIDTH(64)) dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_select (i_select),
      .i_data   (i_data),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_data_0 (o_data_0),
      .o_data_1 (o_data_1),
      .o_data_2 (o_data_2),
      .o_data_3 (o_data_3),
      .o_busy   (o_busy),
      .o_count  (o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] m_valid();
      logic [3:0] v;
      for (int k = 0; k < 4; k++) v[k] = m_full[k];
      return v;
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int k = 0; k < 4; k++) c += m_full[k] ? 1 : 0;
      return c;
   endfunction

   function automatic bit m_ready(input logic [1:0] sel, input logic [3:0] rdy);
      return !m_full[sel] || rdy[sel];
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 4; k++) begin
         m_full[k] = 0;
         m_data[k] = '0;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_valid"}, 64'(o_valid), 64'(m_valid()));
      chk({tag, "_count"}, 64'(o_count), 64'(m_count()));
      chk({tag, "_busy"},  64'(o_busy),  64'(m_count() != 0));
      chk({tag, "_d0"}, o_data_0, m_data[0]);
      chk({tag, "_d1"}, o_data_1, m_data[1]);
      chk({tag, "_d2"}, o_data_2, m_data[2]);
      chk({tag, "_d3"}, o_data_3, m_data[3]);
   endtask

   // Drive one cycle of stimulus, check o_ready before the edge and all state after it.
   task automatic step(input string tag, input bit v, input logic [1:0] sel,
                       input logic [63:0] d, input logic [3:0] rdy);
      bit rd;
      i_valid  = v;
      i_select = sel;
      i_data   = d;
      i_ready  = rdy;
      #1;
      rd = m_ready(sel, rdy);
      chk({tag, "_ready"}, 64'(o_ready), 64'(rd));
      @(posedge clk);
      for (int k = 0; k < 4; k++) if (m_full[k] && rdy[k]) m_full[k] = 0;
      if (v && rd) begin
         m_full[sel] = 1;
         m_data[sel] = d;
      end
      #1;
      check_outputs(tag);
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_select = 2'd0; i_data = '0; i_ready = '0;
      m_reset();
      #2;
      chk("rst_valid", 64'(o_valid), 64'h0);
      chk("rst_count", 64'(o_count), 64'h0);
      chk("rst_ready", 64'(o_ready), 64'h1);
      check_outputs("rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Test 1: single write, then holds while consumer stalls
      step("t1_wr", 1, 2'd2, 64'h0123_4567_89AB_CDEF, 4'b0000);
      chk("t1_valid_lit", 64'(o_valid), 64'h4);
      chk("t1_data_lit", o_data_2, 64'h0123_4567_89AB_CDEF);
      for (int i = 0; i < 5; i++) step("t1_hold", 0, 2'(i), 64'(i), 4'b0000);

      // Test 2: blocked write, then same-cycle replace
      step("t2_block", 1, 2'd2, 64'h55, 4'b0000);
      step("t2_repl", 1, 2'd2, 64'h55, 4'b0100);
      chk("t2_data_lit", o_data_2, 64'h55);
      chk("t2_count_lit", 64'(o_count), 64'd1);

      // Test 3: fill all four channels
      step("t3_clr", 0, 2'd0, 64'h0, 4'b1111);
      for (int k = 0; k < 4; k++) step("t3_wr", 1, 2'(k), 64'hA0 + 64'(k), 4'b0000);
      chk("t3_count_lit", 64'(o_count), 64'd4);
      for (int k = 0; k < 4; k++) begin
         i_valid = 1'b0; i_select = 2'(k); i_ready = 4'b0000;
         #1;
         chk("t3_ready_lit", 64'(o_ready), 64'h0);
      end

      // Test 4: streaming through channel 1 with consumer always ready
      step("t4_clr", 0, 2'd0, 64'h0, 4'b1111);
      for (int i = 1; i <= 8; i++) begin
         step("t4_str", 1, 2'd1, 64'(i), 4'b0010);
         chk("t4_data_lit", o_data_1, 64'(i));
      end
      step("t4_drain", 0, 2'd1, 64'h0, 4'b0010);
      chk("t4_count_lit", 64'(o_count), 64'd0);

      // Test 6: two drains alongside an accept to another channel
      step("t6_w0", 1, 2'd0, 64'h10, 4'b0000);
      step("t6_w3", 1, 2'd3, 64'h13, 4'b0000);
      step("t6_mix", 1, 2'd1, 64'h77, 4'b1001);
      chk("t6_valid_lit", 64'(o_valid), 64'h2);

      // Test 5: asynchronous reset mid-cycle with three channels full
      step("t5_w0", 1, 2'd0, 64'hB0, 4'b0000);
      step("t5_w2", 1, 2'd2, 64'hB2, 4'b0000);
      chk("t5_count_lit", 64'(o_count), 64'd3);
      i_valid = 1'b0; i_ready = 4'b0000;
      #2;
      rst = 1'b1;
      #1;
      m_reset();
      chk("t5_valid_lit", 64'(o_valid), 64'h0);
      chk("t5_busy_lit", 64'(o_busy), 64'h0);
      check_outputs("t5_rst");
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      step("t5_wr", 1, 2'd2, 64'h0123_4567_89AB_CDEF, 4'b0000);
      chk("t5_valid_after", 64'(o_valid), 64'h4);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              {$urandom, $urandom}, 4'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
